// File: rtl/vga_pkg.sv
// Shared VGA framebuffer types, geometry constants and address helper.
package vga_pkg;

    localparam int unsigned H_RES     = 640;
    localparam int unsigned V_RES     = 480;
    localparam int unsigned BURST_LEN = 32;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned GRP_W     = X_W - IDX_W;
    localparam int unsigned BGR_W     = 12;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned ADDR_W    = 25;

    localparam logic [5:0] FB_BANK_ROW = 6'b1;

    typedef logic [BGR_W-1:0]  bgr_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_FILL,
        STATE_FLUSH,
        STATE_REFILL
    } state_t;

    // Single pixel write as held in the pending register.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        bgr_t           bgr;
    } px_t;

    // Burst base address of the 32-pixel group containing (y, grp).
    function automatic fb_addr_t group_addr(input logic [Y_W-1:0] y,
                                            input logic [GRP_W-1:0] grp);
        return {FB_BANK_ROW, y, grp, IDX_W'(0)};
    endfunction

endpackage

// File: rtl/fb_line_buf.sv
// 32-word pixel line buffer with per-word valid mask, one write port and clear.
module fb_line_buf
    import vga_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               we,
    input  logic [IDX_W-1:0]                   idx,
    input  bgr_t                               bgr,
    output logic [BURST_LEN-1:0][WORD_W-1:0]   data,
    output logic [BURST_LEN-1:0]               mask
);

    // Store a word (last write wins) and mark it valid; clear drops the whole group.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data <= '0;
            mask <= '0;
        end else if (we) begin
            data[idx] <= {(WORD_W - BGR_W)'(0), bgr};
            mask[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_fb_writer.sv
// Coalesces single-pixel writes into 32-pixel masked SDRAM burst writes.
// Optional idle auto-flush is enabled by defining VGA_FB_AUTOFLUSH_EN.
module vga_fb_writer
    import vga_pkg::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = 1024
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              px_wr_en,
    input  logic [X_W-1:0]                    px_x,
    input  logic [Y_W-1:0]                    px_y,
    input  bgr_t                              px_bgr,
    output logic                              px_ready,
    input  logic                              flush,
    output logic                              oob,
    output logic                              busy,
    output logic                              fb_wr_req,
    output fb_addr_t                          fb_wr_addr,
    output logic [BURST_LEN-1:0][WORD_W-1:0]  fb_wr_data,
    output logic [BURST_LEN-1:0]              fb_wr_mask,
    input  logic                              fb_wr_done
);

    state_t           state;
    px_t              pend;
    logic             pend_valid;
    logic             accept;
    logic             in_range;
    logic             wr_ok;
    logic             same_grp;
    logic             mask_full;
    logic             timeout;
    logic             lb_we;
    logic             lb_clr;
    logic [IDX_W-1:0] lb_idx;
    bgr_t             lb_bgr;

    fb_line_buf u_line_buf (
        .clk  (clk),
        .rst  (rst),
        .clr  (lb_clr),
        .we   (lb_we),
        .idx  (lb_idx),
        .bgr  (lb_bgr),
        .data (fb_wr_data),
        .mask (fb_wr_mask)
    );

    // Write qualification and group match against the open group's address.
    always_comb begin
        accept    = px_wr_en && px_ready;
        in_range  = (px_x < X_W'(H_RES)) && (px_y < Y_W'(V_RES));
        wr_ok     = accept && in_range;
        same_grp  = (group_addr(px_y, px_x[X_W-1:IDX_W]) == fb_wr_addr);
        mask_full = &fb_wr_mask;
    end

    // Line buffer write port: live pixel in IDLE/FILL, pending pixel in REFILL.
    always_comb begin
        lb_we  = 1'b0;
        lb_idx = px_x[IDX_W-1:0];
        lb_bgr = px_bgr;
        lb_clr = (state == STATE_FLUSH) && fb_wr_done;
        case (state)
            STATE_IDLE:   lb_we = wr_ok;
            STATE_FILL:   lb_we = wr_ok && same_grp;
            STATE_REFILL: begin
                lb_we  = 1'b1;
                lb_idx = pend.x[IDX_W-1:0];
                lb_bgr = pend.bgr;
            end
            default:      lb_we = 1'b0;
        endcase
    end

`ifdef VGA_FB_AUTOFLUSH_EN
    localparam int unsigned CNT_W = $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

    logic [CNT_W-1:0] idle_cnt;

    // Idle cycles since the last accepted write, saturating at the timeout.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_LAST) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    assign timeout = (idle_cnt == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Group FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STATE_IDLE;
            pend       <= '0;
            pend_valid <= 1'b0;
            px_ready   <= 1'b1;
            fb_wr_req  <= 1'b0;
            fb_wr_addr <= '0;
            oob        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            oob <= accept && !in_range;
            case (state)
                STATE_IDLE: begin
                    if (wr_ok) begin
                        fb_wr_addr <= group_addr(px_y, px_x[X_W-1:IDX_W]);
                        busy       <= 1'b1;
                        state      <= STATE_FILL;
                    end
                end
                STATE_FILL: begin
                    if (wr_ok && !same_grp) begin
                        pend       <= '{x: px_x, y: px_y, bgr: px_bgr};
                        pend_valid <= 1'b1;
                        fb_wr_req  <= 1'b1;
                        px_ready   <= 1'b0;
                        state      <= STATE_FLUSH;
                    end else if (flush || mask_full || timeout) begin
                        fb_wr_req  <= 1'b1;
                        px_ready   <= 1'b0;
                        state      <= STATE_FLUSH;
                    end
                end
                STATE_FLUSH: begin
                    if (fb_wr_done) begin
                        fb_wr_req <= 1'b0;
                        if (pend_valid) begin
                            state <= STATE_REFILL;
                        end else begin
                            px_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= STATE_IDLE;
                        end
                    end
                end
                STATE_REFILL: begin
                    fb_wr_addr <= group_addr(pend.y, pend.x[X_W-1:IDX_W]);
                    pend_valid <= 1'b0;
                    px_ready   <= 1'b1;
                    state      <= STATE_FILL;
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Scoreboard bench for vga_fb_writer; also acts as the sdram_ctl burst responder.
module tb_vga_fb_writer;

    typedef struct {
        logic [24:0]       addr;
        logic [31:0]       mask;
        logic [31:0][15:0] data;
    } burst_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              px_wr_en = 1'b0;
    logic [9:0]        px_x = '0;
    logic [8:0]        px_y = '0;
    logic [11:0]       px_bgr = '0;
    logic              px_ready;
    logic              flush = 1'b0;
    logic              oob;
    logic              busy;
    logic              fb_wr_req;
    logic [24:0]       fb_wr_addr;
    logic [31:0][15:0] fb_wr_data;
    logic [31:0]       fb_wr_mask;
    logic              fb_wr_done = 1'b0;

    int checks = 0;
    int failures = 0;
    burst_t exp_q[$];

    vga_fb_writer #(.FLUSH_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .px_wr_en   (px_wr_en),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_bgr     (px_bgr),
        .px_ready   (px_ready),
        .flush      (flush),
        .oob        (oob),
        .busy       (busy),
        .fb_wr_req  (fb_wr_req),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_wr_mask (fb_wr_mask),
        .fb_wr_done (fb_wr_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int x, input int y, input logic [11:0] bgr);
        px_wr_en = 1'b1;
        px_x     = 10'(x);
        px_y     = 9'(y);
        px_bgr   = bgr;
        tick();
        px_wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    function automatic burst_t one_word(input int y, input int x, input logic [11:0] bgr);
        burst_t b;
        b.addr = {6'b1, 9'(y), 10'(x & 32'h3E0)};
        b.mask = 32'h1 << (x % 32);
        b.data = '0;
        b.data[x % 32] = {4'h0, bgr};
        return b;
    endfunction

    // Wait for a burst, compare with the scoreboard head, hold, then complete it.
    task automatic serve_burst(input string name);
        burst_t e;
        int n = 0;
        while (fb_wr_req !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (fb_wr_req !== 1'b1) begin
            failures++;
            $display("FAIL %s_req_timeout: fb_wr_req=%b required 1", name, fb_wr_req);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected_burst: addr=%h with empty scoreboard", name, fb_wr_addr);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (fb_wr_addr !== e.addr) begin
            failures++;
            $display("FAIL %s_addr: got %h required %h", name, fb_wr_addr, e.addr);
        end
        checks++;
        if (fb_wr_mask !== e.mask) begin
            failures++;
            $display("FAIL %s_mask: got %h required %h", name, fb_wr_mask, e.mask);
        end
        checks++;
        if (fb_wr_data !== e.data) begin
            failures++;
            $display("FAIL %s_data: got %h required %h", name, fb_wr_data, e.data);
        end
        repeat (3) tick();
        checks++;
        if (fb_wr_req !== 1'b1 || fb_wr_addr !== e.addr || fb_wr_mask !== e.mask
            || px_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_hold: req=%b addr=%h mask=%h ready=%b required 1/%h/%h/0",
                     name, fb_wr_req, fb_wr_addr, fb_wr_mask, px_ready, e.addr, e.mask);
        end
        fb_wr_done = 1'b1;
        tick();
        fb_wr_done = 1'b0;
        checks++;
        if (fb_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_req_drop: fb_wr_req=%b required 0", name, fb_wr_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if (px_ready !== 1'b1 || fb_wr_req !== 1'b0 || fb_wr_mask !== '0 || fb_wr_data !== '0
            || fb_wr_addr !== '0 || oob !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: ready=%b req=%b mask=%h addr=%h oob=%b busy=%b required 1/0/0/0/0/0",
                     px_ready, fb_wr_req, fb_wr_mask, fb_wr_addr, oob, busy);
        end
    endtask

    task automatic test_full_group();
        burst_t b;
        logic ready_ok = 1'b1;
        b.addr = {6'b1, 9'd0, 10'd0};
        b.mask = '1;
        for (int i = 0; i < 32; i++) b.data[i] = 16'h0800;
        exp_q.push_back(b);
        px_wr_en = 1'b1;
        px_y     = 9'd0;
        px_bgr   = 12'h800;
        for (int i = 0; i < 32; i++) begin
            px_x = 10'(i);
            tick();
            if (px_ready !== 1'b1) ready_ok = 1'b0;
        end
        px_wr_en = 1'b0;
        checks++;
        if (!ready_ok) begin
            failures++;
            $display("FAIL full_throughput: px_ready dropped during same-group writes, required 1");
        end
        checks++;
        if (fb_wr_req !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_pre_req: req=%b busy=%b required 0/1", fb_wr_req, busy);
        end
        tick();
        checks++;
        if (fb_wr_req !== 1'b1 || px_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_latency: req=%b ready=%b required 1/0", fb_wr_req, px_ready);
        end
        serve_burst("full");
        checks++;
        if (px_ready !== 1'b1 || busy !== 1'b0 || fb_wr_mask !== '0) begin
            failures++;
            $display("FAIL full_after_done: ready=%b busy=%b mask=%h required 1/0/0",
                     px_ready, busy, fb_wr_mask);
        end
    endtask

    task automatic test_overwrite_flush();
        exp_q.push_back(one_word(0, 5, 12'h0F0));
        write_px(5, 0, 12'h00F);
        write_px(5, 0, 12'h0F0);
        checks++;
        if (fb_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL overwrite_no_flush: req=%b required 0", fb_wr_req);
        end
        pulse_flush();
        checks++;
        if (fb_wr_req !== 1'b1) begin
            failures++;
            $display("FAIL flush_latency: req=%b required 1", fb_wr_req);
        end
        serve_burst("overwrite");
    endtask

    task automatic test_group_change();
        burst_t b2;
        exp_q.push_back(one_word(1, 0, 12'h123));
        write_px(0, 1, 12'h123);
        write_px(32, 1, 12'h456);
        checks++;
        if (fb_wr_req !== 1'b1 || px_ready !== 1'b0) begin
            failures++;
            $display("FAIL change_latency: req=%b ready=%b required 1/0", fb_wr_req, px_ready);
        end
        serve_burst("change_first");
        checks++;
        if (px_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL refill_state: ready=%b busy=%b required 0/1", px_ready, busy);
        end
        tick();
        b2 = one_word(1, 32, 12'h456);
        checks++;
        if (px_ready !== 1'b1 || fb_wr_mask !== 32'h1 || fb_wr_addr !== b2.addr) begin
            failures++;
            $display("FAIL refill_load: ready=%b mask=%h addr=%h required 1/00000001/%h",
                     px_ready, fb_wr_mask, fb_wr_addr, b2.addr);
        end
        exp_q.push_back(b2);
        pulse_flush();
        serve_burst("change_second");
    endtask

    task automatic test_oob_and_idle_flush();
        logic req_seen = 1'b0;
        write_px(640, 0, 12'hFFF);
        checks++;
        if (oob !== 1'b1) begin
            failures++;
            $display("FAIL oob_x_pulse: oob=%b required 1", oob);
        end
        tick();
        checks++;
        if (oob !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL oob_x_after: oob=%b busy=%b required 0/0", oob, busy);
        end
        write_px(0, 480, 12'hFFF);
        checks++;
        if (oob !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL oob_y_pulse: oob=%b busy=%b required 1/0", oob, busy);
        end
        pulse_flush();
        for (int i = 0; i < 10; i++) begin
            if (fb_wr_req !== 1'b0 || busy !== 1'b0) req_seen = 1'b1;
            tick();
        end
        checks++;
        if (req_seen) begin
            failures++;
            $display("FAIL oob_idle_quiet: request or busy seen after oob writes and idle flush, required none");
        end
    endtask

    task automatic test_reset_mid_burst();
        logic req_seen = 1'b0;
        write_px(3, 2, 12'hABC);
        pulse_flush();
        checks++;
        if (fb_wr_req !== 1'b1) begin
            failures++;
            $display("FAIL midburst_req: req=%b required 1", fb_wr_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (fb_wr_req !== 1'b0 || px_ready !== 1'b1 || busy !== 1'b0 || fb_wr_mask !== '0) begin
            failures++;
            $display("FAIL midburst_reset: req=%b ready=%b busy=%b mask=%h required 0/1/0/0",
                     fb_wr_req, px_ready, busy, fb_wr_mask);
        end
        pulse_flush();
        for (int i = 0; i < 10; i++) begin
            if (fb_wr_req !== 1'b0) req_seen = 1'b1;
            tick();
        end
        checks++;
        if (req_seen) begin
            failures++;
            $display("FAIL midburst_flush_after_reset: request seen, required none");
        end
    endtask

    task automatic test_autoflush();
        int n = 0;
        exp_q.push_back(one_word(3, 7, 12'h321));
        write_px(7, 3, 12'h321);
`ifdef VGA_FB_AUTOFLUSH_EN
        while (fb_wr_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL autoflush_latency: cycles=%0d required 16", n);
        end
`else
        while (fb_wr_req !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (fb_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL no_autoflush: req after %0d cycles, required none within 1000", n);
        end
        pulse_flush();
`endif
        serve_burst("autoflush");
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_overwrite_flush();
        test_group_change();
        test_oob_and_idle_flush();
        test_reset_mid_burst();
        test_autoflush();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d bursts left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
